// File: rtl/wb_write_arbiter.sv
// Writeback arbiter: up to four functional-unit results onto two registered
// register-file write ports, round-robin fair, same-destination collisions serialised.
module wb_write_arbiter (
  input  logic        CLK,
  input  logic        RST,
  input  logic        VLD0,
  input  logic        VLD1,
  input  logic        VLD2,
  input  logic        VLD3,
  input  logic [4:0]  DST0,
  input  logic [4:0]  DST1,
  input  logic [4:0]  DST2,
  input  logic [4:0]  DST3,
  input  logic [31:0] RES0,
  input  logic [31:0] RES1,
  input  logic [31:0] RES2,
  input  logic [31:0] RES3,
  output logic        RDY0,
  output logic        RDY1,
  output logic        RDY2,
  output logic        RDY3,
  output logic        WE1,
  output logic        WE2,
  output logic [4:0]  Aw1,
  output logic [4:0]  Aw2,
  output logic [31:0] WD1,
  output logic [31:0] WD2,
  output logic [15:0] CONF_CNT
);

  logic [3:0]  vld;
  logic [4:0]  dst [4];
  logic [31:0] res [4];
  logic [3:0]  req_nz;
  logic [3:0]  rdy;

  logic [1:0]  p_q, p_d;
  logic        we1_q, we1_d, we2_q, we2_d;
  logic [4:0]  aw1_q, aw1_d, aw2_q, aw2_d;
  logic [31:0] wd1_q, wd1_d, wd2_q, wd2_d;
  logic [15:0] cnt_q, cnt_d;

  logic        g1_vld, g2_vld;
  logic [1:0]  g1_idx, g2_idx;
  logic [1:0]  scan_idx;
  logic        stall;

  assign vld = {VLD3, VLD2, VLD1, VLD0};

  always_comb begin
    dst[0] = DST0;
    dst[1] = DST1;
    dst[2] = DST2;
    dst[3] = DST3;
    res[0] = RES0;
    res[1] = RES1;
    res[2] = RES2;
    res[3] = RES3;
  end

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      req_nz[i] = vld[i] && (dst[i] != 5'd0);
    end
  end

  // Grant selection looks only at VLD/DST and the pointer, never at RES.
  always_comb begin
    g1_vld   = 1'b0;
    g1_idx   = 2'd0;
    g2_vld   = 1'b0;
    g2_idx   = 2'd0;
    scan_idx = 2'd0;
    for (int k = 0; k < 4; k++) begin
      scan_idx = p_q + 2'(k);
      if (req_nz[scan_idx]) begin
        if (!g1_vld) begin
          g1_vld = 1'b1;
          g1_idx = scan_idx;
        end else if (!g2_vld && (dst[scan_idx] != dst[g1_idx])) begin
          g2_vld = 1'b1;
          g2_idx = scan_idx;
        end
      end
    end
  end

  always_comb begin
    rdy = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      rdy[i] = !RST && vld[i] &&
               ((dst[i] == 5'd0) ||
                (g1_vld && (g1_idx == 2'(i))) ||
                (g2_vld && (g2_idx == 2'(i))));
    end
  end

  assign RDY0  = rdy[0];
  assign RDY1  = rdy[1];
  assign RDY2  = rdy[2];
  assign RDY3  = rdy[3];
  assign stall = |(req_nz & ~rdy);

  always_comb begin
    p_d = p_q;
    if (g1_vld) begin
      p_d = (g2_vld ? g2_idx : g1_idx) + 2'd1;
    end

    cnt_d = cnt_q;
    if (stall && (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'd1;
    end

    // A lone grant always lands on port 1; idle ports drive zeros.
    we1_d = g1_vld;
    aw1_d = g1_vld ? dst[g1_idx] : 5'd0;
    wd1_d = g1_vld ? res[g1_idx] : 32'd0;
    we2_d = g2_vld;
    aw2_d = g2_vld ? dst[g2_idx] : 5'd0;
    wd2_d = g2_vld ? res[g2_idx] : 32'd0;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      p_q   <= 2'd0;
      cnt_q <= 16'd0;
      we1_q <= 1'b0;
      aw1_q <= 5'd0;
      wd1_q <= 32'd0;
      we2_q <= 1'b0;
      aw2_q <= 5'd0;
      wd2_q <= 32'd0;
    end else begin
      p_q   <= p_d;
      cnt_q <= cnt_d;
      we1_q <= we1_d;
      aw1_q <= aw1_d;
      wd1_q <= wd1_d;
      we2_q <= we2_d;
      aw2_q <= aw2_d;
      wd2_q <= wd2_d;
    end
  end

  assign WE1      = we1_q;
  assign WE2      = we2_q;
  assign Aw1      = aw1_q;
  assign Aw2      = aw2_q;
  assign WD1      = wd1_q;
  assign WD2      = wd2_q;
  assign CONF_CNT = cnt_q;

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Directed bench for wb_write_arbiter: inputs change on the falling edge,
// RDY is sampled mid-low-phase, registered outputs are sampled just after the rising edge.
module tb_wb_write_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  vld;
  logic [4:0]  dst [4];
  logic [31:0] res [4];
  logic        rdy0, rdy1, rdy2, rdy3;
  logic [3:0]  rdy;
  logic        we1, we2;
  logic [4:0]  aw1, aw2;
  logic [31:0] wd1, wd2;
  logic [15:0] conf_cnt;

  int n_cmp = 0;
  int n_err = 0;

  wb_write_arbiter dut (
    .CLK(clk), .RST(rst),
    .VLD0(vld[0]), .VLD1(vld[1]), .VLD2(vld[2]), .VLD3(vld[3]),
    .DST0(dst[0]), .DST1(dst[1]), .DST2(dst[2]), .DST3(dst[3]),
    .RES0(res[0]), .RES1(res[1]), .RES2(res[2]), .RES3(res[3]),
    .RDY0(rdy0), .RDY1(rdy1), .RDY2(rdy2), .RDY3(rdy3),
    .WE1(we1), .WE2(we2), .Aw1(aw1), .Aw2(aw2), .WD1(wd1), .WD2(wd2),
    .CONF_CNT(conf_cnt)
  );

  assign rdy = {rdy3, rdy2, rdy1, rdy0};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_inputs();
    vld = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      dst[i] = 5'd0;
      res[i] = 32'h1000_0000 + 32'(i);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    clear_inputs();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    vld = 4'b1111;
    dst[0] = 5'd1; dst[1] = 5'd2; dst[2] = 5'd0; dst[3] = 5'd4;
    #1;
    n_cmp++;
    if (rdy !== 4'b0000) begin
      n_err++; $display("FAIL reset_rdy got=%b exp=%b", rdy, 4'b0000);
    end
    @(posedge clk); #1;
    n_cmp++;
    if ({we1, we2, aw1, aw2, wd1, wd2} !== 76'd0) begin
      n_err++; $display("FAIL reset_ports got we=%b%b aw=%0d,%0d wd=%h,%h exp all zero",
                        we1, we2, aw1, aw2, wd1, wd2);
    end
    n_cmp++;
    if (conf_cnt !== 16'd0 || dut.p_q !== 2'd0) begin
      n_err++; $display("FAIL reset_cnt_p got cnt=%0d p=%0d exp cnt=0 p=0", conf_cnt, dut.p_q);
    end
    rst = 1'b0;
    clear_inputs();
  endtask

  task automatic test_round_robin();
    do_reset();
    @(negedge clk);
    vld = 4'b1111;
    dst[0] = 5'd1; dst[1] = 5'd2; dst[2] = 5'd3; dst[3] = 5'd4;
    #1;
    n_cmp++;
    if (rdy !== 4'b0011) begin
      n_err++; $display("FAIL rr_rdy0 got=%b exp=%b", rdy, 4'b0011);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (we1 !== 1'b1 || aw1 !== 5'd1 || wd1 !== 32'h1000_0000 ||
        we2 !== 1'b1 || aw2 !== 5'd2 || wd2 !== 32'h1000_0001) begin
      n_err++; $display("FAIL rr_out0 got we1=%b aw1=%0d wd1=%h we2=%b aw2=%0d wd2=%h exp 1,1,10000000,1,2,10000001",
                        we1, aw1, wd1, we2, aw2, wd2);
    end
    n_cmp++;
    if (dut.p_q !== 2'd2 || conf_cnt !== 16'd1) begin
      n_err++; $display("FAIL rr_p_cnt0 got p=%0d cnt=%0d exp p=2 cnt=1", dut.p_q, conf_cnt);
    end
    @(negedge clk);
    vld = 4'b1100;
    #1;
    n_cmp++;
    if (rdy !== 4'b1100) begin
      n_err++; $display("FAIL rr_rdy1 got=%b exp=%b", rdy, 4'b1100);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (we1 !== 1'b1 || aw1 !== 5'd3 || wd1 !== 32'h1000_0002 ||
        we2 !== 1'b1 || aw2 !== 5'd4 || wd2 !== 32'h1000_0003) begin
      n_err++; $display("FAIL rr_out1 got we1=%b aw1=%0d wd1=%h we2=%b aw2=%0d wd2=%h exp 1,3,10000002,1,4,10000003",
                        we1, aw1, wd1, we2, aw2, wd2);
    end
    n_cmp++;
    if (dut.p_q !== 2'd0 || conf_cnt !== 16'd1) begin
      n_err++; $display("FAIL rr_p_cnt1 got p=%0d cnt=%0d exp p=0 cnt=1", dut.p_q, conf_cnt);
    end
    @(negedge clk);
    clear_inputs();
  endtask

  // Same destination from two units; then zero-destination discard; then idle.
  task automatic test_same_dst_discard_idle();
    do_reset();
    @(negedge clk);
    vld = 4'b0011;
    dst[0] = 5'd5; dst[1] = 5'd5;
    res[0] = 32'hAAAA_0000; res[1] = 32'hBBBB_1111;
    #1;
    n_cmp++;
    if (rdy !== 4'b0001) begin
      n_err++; $display("FAIL same_rdy0 got=%b exp=%b", rdy, 4'b0001);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (we1 !== 1'b1 || aw1 !== 5'd5 || wd1 !== 32'hAAAA_0000 || we2 !== 1'b0 ||
        aw2 !== 5'd0 || wd2 !== 32'd0 || conf_cnt !== 16'd1) begin
      n_err++; $display("FAIL same_out0 got we1=%b aw1=%0d wd1=%h we2=%b aw2=%0d wd2=%h cnt=%0d exp 1,5,aaaa0000,0,0,0,1",
                        we1, aw1, wd1, we2, aw2, wd2, conf_cnt);
    end
    @(negedge clk);
    vld = 4'b0010;
    #1;
    n_cmp++;
    if (rdy !== 4'b0010) begin
      n_err++; $display("FAIL same_rdy1 got=%b exp=%b", rdy, 4'b0010);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (we1 !== 1'b1 || aw1 !== 5'd5 || wd1 !== 32'hBBBB_1111 || we2 !== 1'b0 || dut.p_q !== 2'd2) begin
      n_err++; $display("FAIL same_out1 got we1=%b aw1=%0d wd1=%h we2=%b p=%0d exp 1,5,bbbb1111,0,2",
                        we1, aw1, wd1, we2, dut.p_q);
    end
    @(negedge clk);
    vld = 4'b1100;
    dst[2] = 5'd0; dst[3] = 5'd7;
    res[2] = 32'h5555_5555; res[3] = 32'hDEAD_BEEF;
    #1;
    n_cmp++;
    if (rdy !== 4'b1100) begin
      n_err++; $display("FAIL discard_rdy got=%b exp=%b", rdy, 4'b1100);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (we1 !== 1'b1 || aw1 !== 5'd7 || wd1 !== 32'hDEAD_BEEF || we2 !== 1'b0 ||
        wd2 !== 32'd0 || conf_cnt !== 16'd1 || dut.p_q !== 2'd0) begin
      n_err++; $display("FAIL discard_out got we1=%b aw1=%0d wd1=%h we2=%b wd2=%h cnt=%0d p=%0d exp 1,7,deadbeef,0,0,1,0",
                        we1, aw1, wd1, we2, wd2, conf_cnt, dut.p_q);
    end
    @(negedge clk);
    clear_inputs();
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      n_cmp++;
      if (we1 !== 1'b0 || we2 !== 1'b0 || aw1 !== 5'd0 || wd1 !== 32'd0 ||
          conf_cnt !== 16'd1 || dut.p_q !== 2'd0) begin
        n_err++; $display("FAIL idle_%0d got we=%b%b aw1=%0d wd1=%h cnt=%0d p=%0d exp 0,0,0,0,1,0",
                          c, we1, we2, aw1, wd1, conf_cnt, dut.p_q);
      end
    end
  endtask

  // Port 2 skips a same-destination request and takes the next distinct one.
  task automatic test_skip_same();
    do_reset();
    @(negedge clk);
    vld = 4'b0111;
    dst[0] = 5'd6; dst[1] = 5'd6; dst[2] = 5'd9;
    #1;
    n_cmp++;
    if (rdy !== 4'b0101) begin
      n_err++; $display("FAIL skip_rdy got=%b exp=%b", rdy, 4'b0101);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (we1 !== 1'b1 || aw1 !== 5'd6 || wd1 !== 32'h1000_0000 || we2 !== 1'b1 || aw2 !== 5'd9 ||
        wd2 !== 32'h1000_0002 || dut.p_q !== 2'd3 || conf_cnt !== 16'd1) begin
      n_err++; $display("FAIL skip_out got aw1=%0d wd1=%h aw2=%0d wd2=%h we=%b%b p=%0d cnt=%0d exp 6,10000000,9,10000002,11,3,1",
                        aw1, wd1, aw2, wd2, we1, we2, dut.p_q, conf_cnt);
    end
    @(negedge clk);
    clear_inputs();
  endtask

  task automatic test_reset_mid();
    do_reset();
    @(negedge clk);
    vld = 4'b1111;
    dst[0] = 5'd1; dst[1] = 5'd2; dst[2] = 5'd3; dst[3] = 5'd4;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_cmp++;
    if (rdy !== 4'b0000) begin
      n_err++; $display("FAIL mid_rst_rdy got=%b exp=%b", rdy, 4'b0000);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (we1 !== 1'b0 || we2 !== 1'b0 || aw1 !== 5'd0 || aw2 !== 5'd0 ||
        dut.p_q !== 2'd0 || conf_cnt !== 16'd0) begin
      n_err++; $display("FAIL mid_rst_out got we=%b%b aw=%0d,%0d p=%0d cnt=%0d exp zeros",
                        we1, we2, aw1, aw2, dut.p_q, conf_cnt);
    end
    @(negedge clk);
    rst = 1'b0;
    vld = 4'b1001;
    dst[0] = 5'd8; dst[3] = 5'd9;
    #1;
    n_cmp++;
    if (rdy !== 4'b1001) begin
      n_err++; $display("FAIL post_rst_rdy got=%b exp=%b", rdy, 4'b1001);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (aw1 !== 5'd8 || aw2 !== 5'd9 || wd1 !== 32'h1000_0000 || wd2 !== 32'h1000_0003 || dut.p_q !== 2'd0) begin
      n_err++; $display("FAIL post_rst_out got aw1=%0d aw2=%0d wd1=%h wd2=%h p=%0d exp 8,9,10000000,10000003,0",
                        aw1, aw2, wd1, wd2, dut.p_q);
    end
    @(negedge clk);
    clear_inputs();
  endtask

  // Three always-valid distinct requests: one stalls every cycle, counter saturates.
  task automatic test_saturate();
    int miss [3];
    int max_miss;
    do_reset();
    miss = '{0, 0, 0};
    max_miss = 0;
    @(negedge clk);
    vld = 4'b0111;
    dst[0] = 5'd1; dst[1] = 5'd2; dst[2] = 5'd3;
    for (int c = 0; c < 66000; c++) begin
      #1;
      for (int i = 0; i < 3; i++) begin
        miss[i] = rdy[i] ? 0 : miss[i] + 1;
        if (miss[i] > max_miss) max_miss = miss[i];
      end
      @(negedge clk);
    end
    n_cmp++;
    if (max_miss > 1) begin
      n_err++; $display("FAIL sat_fairness got max_consecutive_misses=%0d exp<=1", max_miss);
    end
    n_cmp++;
    if (conf_cnt !== 16'hFFFF) begin
      n_err++; $display("FAIL sat_cnt got=%h exp=ffff", conf_cnt);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (conf_cnt !== 16'hFFFF) begin
      n_err++; $display("FAIL sat_hold got=%h exp=ffff", conf_cnt);
    end
    @(negedge clk);
    clear_inputs();
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    test_reset();
    test_round_robin();
    test_same_dst_discard_idle();
    test_skip_same();
    test_reset_mid();
    test_saturate();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
